// File: rtl/tod_pkg.sv
// Shared definitions for the time-of-day controller.
//   mode_t      : controller mode encoding, which is also driven onto MODE
//   HOURS_MAX   : last legal hours value (BCD)
//   MIN_SEC_MAX : last legal minutes/seconds value (BCD)
//   bcd_inc     : two-digit BCD increment that wraps to 00 after a limit
package tod_pkg;

   typedef enum logic [1:0] {
      MODE_RUN         = 2'd0,
      MODE_SET_HOURS   = 2'd1,
      MODE_SET_MINUTES = 2'd2
   } mode_t;

   localparam logic [7:0] HOURS_MAX   = 8'h23;
   localparam logic [7:0] MIN_SEC_MAX = 8'h59;

   // The units digit rolls 9->0 and carries into tens in the same step.
   // Wrapping at the limit keeps every result a legal BCD value.
   function automatic logic [7:0] bcd_inc(input logic [7:0] val, input logic [7:0] lim);
      logic [7:0] res;
      if (val == lim)
         res = 8'h00;
      else if (val[3:0] == 4'd9)
         res = {val[7:4] + 4'd1, 4'h0};
      else
         res = {val[7:4], val[3:0] + 4'd1};
      return res;
   endfunction

endpackage

// File: rtl/tod_debounce.sv
// Pushbutton conditioner: 2-FF synchronizer, stability timer, rise strobe.
//   clk   : system clock
//   rst   : asynchronous active-high reset
//   btn   : raw button level, asynchronous to clk
//   press : one-cycle strobe when the accepted level goes 0->1
// The accepted level changes only after DEBOUNCE_CYCLES consecutive
// synchronized samples that differ from it. Release changes the level
// but makes no strobe. The strobe is high in the cycle whose closing edge
// accepts the new level, so a consumer registers it 2 + DEBOUNCE_CYCLES
// edges after the raw input rises.
module tod_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic press
);

   localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync_1;
   logic          sync_2;
   logic          level;
   logic [CW-1:0] stable_cnt;
   logic          accept;

   // Down-counter: reloaded while the sample matches the accepted level,
   // so reaching zero means DEBOUNCE_CYCLES differing samples in a row.
   assign accept = (sync_2 != level) && (stable_cnt == '0);
   assign press  = accept && sync_2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_1     <= 1'b0;
         sync_2     <= 1'b0;
         level      <= 1'b0;
         stable_cnt <= CNT_LOAD;
      end else begin
         sync_1 <= btn;
         sync_2 <= sync_1;
         if (sync_2 == level) begin
            stable_cnt <= CNT_LOAD;
         end else if (accept) begin
            level      <= sync_2;
            stable_cnt <= CNT_LOAD;
         end else begin
            stable_cnt <= stable_cnt - 1'b1;
         end
      end
   end

endmodule

// File: rtl/tod_ctrl.sv
// Time-of-day sequencing controller: 1 Hz prescaler, BCD HH:MM:SS keeping,
// and a RUN / SET_HOURS / SET_MINUTES mode machine driven by two buttons.
//   CLOCK_50    : system clock
//   RESET       : asynchronous active-high reset
//   BTN_MODE    : mode button (active-high, asynchronous)
//   BTN_INC     : increment button (active-high, asynchronous)
//   HOURS_BCD   : {tens,units} 00..23
//   MINUTES_BCD : {tens,units} 00..59
//   SECONDS_BCD : {tens,units} 00..59
//   MODE        : 0=RUN, 1=SET_HOURS, 2=SET_MINUTES
//   SEC_PULSE   : one-cycle pulse on every seconds increment
//   DIGIT_BLANK : bit i blanks HEX digit i
// Build option TOD_BLINK_EN: blink the digits being edited with period
// CLK_HZ; without it DIGIT_BLANK is constant zero.
//
// state            | meaning
// MODE_RUN         | time advances once per CLK_HZ cycles, inc ignored
// MODE_SET_HOURS   | clock frozen, inc advances hours 23->00
// MODE_SET_MINUTES | clock frozen, inc advances minutes 59->00, no carry
module tod_ctrl
   import tod_pkg::*;
#(
   parameter int unsigned CLK_HZ          = 50000000,
   parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
   input  logic       CLOCK_50,
   input  logic       RESET,
   input  logic       BTN_MODE,
   input  logic       BTN_INC,
   output logic [7:0] HOURS_BCD,
   output logic [7:0] MINUTES_BCD,
   output logic [7:0] SECONDS_BCD,
   output logic [1:0] MODE,
   output logic       SEC_PULSE,
   output logic [3:0] DIGIT_BLANK
);

   localparam int unsigned PW = $clog2(CLK_HZ);
   localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);

   mode_t         state;
   mode_t         state_next;
   logic          mode_press;
   logic          inc_press;
   logic [PW-1:0] presc;
   logic          tick;
   logic          enter_set;

   tod_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_mode (
      .clk   (CLOCK_50),
      .rst   (RESET),
      .btn   (BTN_MODE),
      .press (mode_press)
   );

   tod_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_inc (
      .clk   (CLOCK_50),
      .rst   (RESET),
      .btn   (BTN_INC),
      .press (inc_press)
   );

   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET)
         state <= MODE_RUN;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (mode_press) begin
         case (state)
            MODE_RUN:         state_next = MODE_SET_HOURS;
            MODE_SET_HOURS:   state_next = MODE_SET_MINUTES;
            MODE_SET_MINUTES: state_next = MODE_RUN;
            default:          state_next = MODE_RUN;
         endcase
      end
   end

`ifdef TOD_BLINK_EN
   logic [PW-1:0] blink_cnt;
   logic          blink_phase;

   // Restarting on every mode change makes the edited digits visible first.
   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET)
         blink_cnt <= '0;
      else if (state_next != state || blink_cnt == PRESC_LAST)
         blink_cnt <= '0;
      else
         blink_cnt <= blink_cnt + 1'b1;
   end

   assign blink_phase = (blink_cnt >= PW'(CLK_HZ / 2));
`endif

   always_comb begin
      MODE        = state;
      DIGIT_BLANK = 4'b0000;
`ifdef TOD_BLINK_EN
      if (blink_phase) begin
         case (state)
            MODE_SET_HOURS:   DIGIT_BLANK = 4'b1100;
            MODE_SET_MINUTES: DIGIT_BLANK = 4'b0011;
            default:          DIGIT_BLANK = 4'b0000;
         endcase
      end
`endif
   end

   // A tick on the same edge that leaves RUN is suppressed; the entry into
   // SET_HOURS clears seconds anyway.
   assign enter_set = (state == MODE_RUN) && (state_next == MODE_SET_HOURS);
   assign tick      = (state == MODE_RUN) && (state_next == MODE_RUN) && (presc == PRESC_LAST);

   // Held at zero outside RUN, so the first tick after returning to RUN
   // lands exactly CLK_HZ cycles after the mode change.
   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET)
         presc <= '0;
      else if (state_next != MODE_RUN || state != MODE_RUN || tick)
         presc <= '0;
      else
         presc <= presc + 1'b1;
   end

   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         HOURS_BCD   <= 8'h00;
         MINUTES_BCD <= 8'h00;
         SECONDS_BCD <= 8'h00;
         SEC_PULSE   <= 1'b0;
      end else begin
         SEC_PULSE <= tick;
         if (enter_set) begin
            SECONDS_BCD <= 8'h00;
         end else if (tick) begin
            SECONDS_BCD <= bcd_inc(SECONDS_BCD, MIN_SEC_MAX);
            if (SECONDS_BCD == MIN_SEC_MAX) begin
               MINUTES_BCD <= bcd_inc(MINUTES_BCD, MIN_SEC_MAX);
               if (MINUTES_BCD == MIN_SEC_MAX)
                  HOURS_BCD <= bcd_inc(HOURS_BCD, HOURS_MAX);
            end
         end else if (inc_press && !mode_press) begin
            if (state == MODE_SET_HOURS)
               HOURS_BCD <= bcd_inc(HOURS_BCD, HOURS_MAX);
            else if (state == MODE_SET_MINUTES)
               MINUTES_BCD <= bcd_inc(MINUTES_BCD, MIN_SEC_MAX);
         end
      end
   end

endmodule

// File: tb/tb_tod_ctrl.sv
// Directed bench for tod_ctrl with CLK_HZ=10, DEBOUNCE_CYCLES=4.
// A clean press registers in the DUT on the 6th rising edge after the
// button is driven (2 sync + 4 stable samples).
module tb_tod_ctrl;

   logic       clk;
   logic       rst;
   logic       btn_mode;
   logic       btn_inc;
   logic [7:0] hours;
   logic [7:0] minutes;
   logic [7:0] seconds;
   logic [1:0] mode;
   logic       sec_pulse;
   logic [3:0] digit_blank;

   int n_vec;
   int n_err;

   tod_ctrl #(.CLK_HZ(10), .DEBOUNCE_CYCLES(4)) dut (
      .CLOCK_50    (clk),
      .RESET       (rst),
      .BTN_MODE    (btn_mode),
      .BTN_INC     (btn_inc),
      .HOURS_BCD   (hours),
      .MINUTES_BCD (minutes),
      .SECONDS_BCD (seconds),
      .MODE        (mode),
      .SEC_PULSE   (sec_pulse),
      .DIGIT_BLANK (digit_blank)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic press_mode();
      btn_mode = 1'b1;
      repeat (6) step();
      btn_mode = 1'b0;
      repeat (6) step();
   endtask

   task automatic press_inc(input int n);
      for (int i = 0; i < n; i++) begin
         btn_inc = 1'b1;
         repeat (6) step();
         btn_inc = 1'b0;
         repeat (6) step();
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_hours"},   32'(hours),       32'h00);
      chk({tag, "_minutes"}, 32'(minutes),     32'h00);
      chk({tag, "_seconds"}, 32'(seconds),     32'h00);
      chk({tag, "_mode"},    32'(mode),        32'd0);
      chk({tag, "_pulse"},   32'(sec_pulse),   32'd0);
      chk({tag, "_blank"},   32'(digit_blank), 32'h0);
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk_reset_vals(tag);
      @(negedge clk);
      rst = 1'b0;
   endtask

   function automatic logic [7:0] to_bcd(input int v);
      logic [3:0] t;
      logic [3:0] u;
      t = 4'(v / 10);
      u = 4'(v % 10);
      return {t, u};
   endfunction

   initial begin
      int pulses;
      logic [3:0] exp_blank;
      n_vec    = 0;
      n_err    = 0;
      rst      = 1'b0;
      btn_mode = 1'b0;
      btn_inc  = 1'b0;

      do_reset("rst0");

      // Free run for one minute from reset.
      pulses = 0;
      for (int i = 1; i <= 600; i++) begin
         step();
         if (sec_pulse) pulses++;
         chk("run_pulse", 32'(sec_pulse), 32'((i % 10) == 0));
         if (i == 10)  chk("run_sec_10", 32'(seconds), 32'h01);
         if (i == 599) begin
            chk("run_sec_599", 32'(seconds), 32'h59);
            chk("run_min_599", 32'(minutes), 32'h00);
         end
         if (i == 600) begin
            chk("run_sec_600", 32'(seconds), 32'h00);
            chk("run_min_600", 32'(minutes), 32'h01);
            chk("run_blank", 32'(digit_blank), 32'h0);
         end
      end
      chk("run_pulse_count", 32'(pulses), 32'd60);

      do_reset("rst1");

      // Bounce 1,0,1 then hold: one strobe, 6 edges after the last rise.
      @(posedge clk); #1;
      btn_mode = 1'b1; step();
      btn_mode = 1'b0; step();
      btn_mode = 1'b1;
      repeat (5) step();
      chk("bounce_mode_5", 32'(mode), 32'd0);
      step();
      chk("bounce_mode_6", 32'(mode), 32'd1);
      chk("bounce_sec_clr", 32'(seconds), 32'h00);
      repeat (4) step();
      btn_mode = 1'b0;
      repeat (8) step();
      chk("bounce_single", 32'(mode), 32'd1);

      // Hours wrap through 23->00 and no seconds movement while editing.
      press_inc(25);
      chk("seth_hours", 32'(hours), 32'h01);
      chk("seth_sec", 32'(seconds), 32'h00);
      press_mode();
      chk("setm_mode", 32'(mode), 32'd2);
      press_inc(61);
      chk("setm_minutes", 32'(minutes), 32'h01);
      chk("setm_hours", 32'(hours), 32'h01);
      chk("setm_sec", 32'(seconds), 32'h00);

      // Simultaneous mode and inc in SET_HOURS: mode wins.
      press_mode();
      chk("back_run", 32'(mode), 32'd0);
      press_mode();
      chk("seth_again", 32'(mode), 32'd1);
      btn_mode = 1'b1;
      btn_inc  = 1'b1;
      repeat (6) step();
      chk("both_mode", 32'(mode), 32'd2);
      chk("both_hours", 32'(hours), 32'h01);
      btn_mode = 1'b0;
      btn_inc  = 1'b0;
      repeat (6) step();

      // Set 12:34, checking the blink pattern on entry to SET_MINUTES.
      press_mode();
      press_mode();
      press_inc(11);
      chk("preset_h12", 32'(hours), 32'h12);
      btn_mode = 1'b1;
      repeat (6) step();
      chk("blink_mode", 32'(mode), 32'd2);
      for (int k = 0; k < 20; k++) begin
`ifdef TOD_BLINK_EN
         exp_blank = ((k % 10) >= 5) ? 4'b0011 : 4'b0000;
`else
         exp_blank = 4'b0000;
`endif
         chk("blink_setm", 32'(digit_blank), 32'(exp_blank));
         step();
      end
      btn_mode = 1'b0;
      repeat (6) step();
      press_inc(33);
      chk("preset_h", 32'(hours), 32'h12);
      chk("preset_m", 32'(minutes), 32'h34);
      chk("preset_mode", 32'(mode), 32'd2);

      // Reset mid-cycle while editing: immediate return to reset values.
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk_reset_vals("rst_edit");
      @(negedge clk);
      rst = 1'b0;
      repeat (8) step();
      chk("post_rst_mode", 32'(mode), 32'd0);

      // Preset 23:59, return to RUN, and roll over midnight.
      press_mode();
      press_inc(23);
      press_mode();
      press_inc(59);
      chk("mid_h", 32'(hours), 32'h23);
      chk("mid_m", 32'(minutes), 32'h59);
      chk("mid_s", 32'(seconds), 32'h00);
      btn_mode = 1'b1;
      repeat (6) step();
      chk("mid_run", 32'(mode), 32'd0);
      btn_mode = 1'b0;
      for (int k = 1; k <= 601; k++) begin
         step();
         if (k == 9)  chk("first_tick_9", 32'(seconds), 32'h00);
         if (k == 10) begin
            chk("first_tick_10", 32'(seconds), 32'h01);
            chk("first_tick_pulse", 32'(sec_pulse), 32'd1);
         end
         if (k == 300) chk("mid_sec_300", 32'(seconds), 32'(to_bcd(30)));
         if (k == 305) chk("run_blank_0", 32'(digit_blank), 32'h0);
         if (k == 599) begin
            chk("pre_wrap_h", 32'(hours), 32'h23);
            chk("pre_wrap_m", 32'(minutes), 32'h59);
            chk("pre_wrap_s", 32'(seconds), 32'h59);
            chk("pre_wrap_pulse", 32'(sec_pulse), 32'd0);
         end
         if (k == 600) begin
            chk("wrap_h", 32'(hours), 32'h00);
            chk("wrap_m", 32'(minutes), 32'h00);
            chk("wrap_s", 32'(seconds), 32'h00);
            chk("wrap_pulse", 32'(sec_pulse), 32'd1);
         end
         if (k == 601) chk("wrap_pulse_end", 32'(sec_pulse), 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
